// File: rtl/pipe_register_pkg.sv
// Shared constants and helpers for the elastic pipe register.
package pipe_register_pkg;

  // Deepest chain the block is built and verified for.
  localparam int STAGES_MAX = 16;

  // Width of a counter that must hold every value from 0 to stages.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  // True when the requested depth is one the block supports.
  function automatic bit stages_legal(input int stages);
    return (stages >= 1) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a valid flag plus a data word. The stage takes a new
// word whenever it is empty or the stage after it is draining.
module pipe_stage
  import pipe_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  assign rdy = !vld_q || dn_ready;
  assign vld = vld_q;
  assign dat = dat_q;

  // Load upstream valid when ready; only overwrite data with a valid word,
  // so garbage on an idle upstream never lands in the register.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy) begin
      vld_d = up_valid;
      if (up_valid) begin
        dat_d = up_data;
      end
    end
  end

  // Reset and flush both empty the stage and reload the idle data value.
  always_ff @(posedge clk) begin
    if (rst_ || flush) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Elastic chain of STAGES registers with valid/ready handshakes on both ends,
// full-throughput backpressure, synchronous flush and an occupancy count.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [cnt_w(STAGES)-1:0]   count
);

  localparam int CW = cnt_w(STAGES);

  if (!stages_legal(STAGES)) begin : gBadStages
    $error("pipe_register: STAGES=%0d outside 1..%0d", STAGES, STAGES_MAX);
  end

  // rdyChain[i] is the ready of stage i; the extra top entry is the consumer.
  logic [STAGES:0]  rdyChain;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0] dat [STAGES];

  logic          inXfer;
  logic          outXfer;
  logic [CW-1:0] count_q, count_d;

  assign rdyChain[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    logic             upValid;
    logic [WIDTH-1:0] upData;

    if (i == 0) begin : gHead
      assign upValid = in_valid;
      assign upData  = in_data;
    end else begin : gBody
      assign upValid = vld[i-1];
      assign upData  = dat[i-1];
    end

    pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) uStage (
      .clk     (clk),
      .rst_    (rst_),
      .flush   (flush),
      .up_valid(upValid),
      .up_data (upData),
      .dn_ready(rdyChain[i+1]),
      .rdy     (rdyChain[i]),
      .vld     (vld[i]),
      .dat     (dat[i])
    );
  end

  assign in_ready  = rdyChain[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];
  assign count     = count_q;

  assign inXfer  = in_valid && in_ready;
  assign outXfer = out_valid && out_ready;

  // Occupancy moves by one per accepted word and back by one per drained word.
  always_comb begin
    count_d = count_q + CW'(inXfer) - CW'(outXfer);
  end

  // Occupancy register; reset and flush discard everything in flight.
  always_ff @(posedge clk) begin
    if (rst_ || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench: directed scenarios on a 2-stage byte pipe plus a
// randomized sweep over other depths/widths against a FIFO reference model.
module tb_pipe_register;

  int asserts  = 0;
  int failures = 0;

  logic clk;
  logic rst_;
  logic flush;

  // Main instance: WIDTH=8, STAGES=2.
  logic       inValid, inReady, outValid, outReady;
  logic [7:0] inData, outData;
  logic [1:0] count;

  pipe_register #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_(rst_), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .count(count)
  );

  // Sweep instances: (STAGES,WIDTH) = (1,8), (4,32), (16,1).
  logic        sValid [3];
  logic        sReady [3];
  logic [31:0] sData  [3];
  logic        sIr    [3];
  logic        sOv    [3];
  logic [7:0]  o0;
  logic [31:0] o1;
  logic [0:0]  o2;
  logic [0:0]  c0;
  logic [2:0]  c1;
  logic [4:0]  c2;

  pipe_register #(.WIDTH(8), .STAGES(1)) dutS1 (
    .clk(clk), .rst_(rst_), .flush(flush),
    .in_valid(sValid[0]), .in_ready(sIr[0]), .in_data(sData[0][7:0]),
    .out_valid(sOv[0]), .out_ready(sReady[0]), .out_data(o0), .count(c0)
  );

  pipe_register #(.WIDTH(32), .STAGES(4)) dutS4 (
    .clk(clk), .rst_(rst_), .flush(flush),
    .in_valid(sValid[1]), .in_ready(sIr[1]), .in_data(sData[1]),
    .out_valid(sOv[1]), .out_ready(sReady[1]), .out_data(o1), .count(c1)
  );

  pipe_register #(.WIDTH(1), .STAGES(16)) dutS16 (
    .clk(clk), .rst_(rst_), .flush(flush),
    .in_valid(sValid[2]), .in_ready(sIr[2]), .in_data(sData[2][0:0]),
    .out_valid(sOv[2]), .out_ready(sReady[2]), .out_data(o2), .count(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the sweep: words in flight, oldest first.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  function automatic int qSize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qFront(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qPush(input int k, input logic [31:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic qPop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  function automatic logic [31:0] outOf(input int k);
    case (k)
      0:       return 32'(o0);
      1:       return o1;
      default: return 32'(o2);
    endcase
  endfunction

  function automatic int cntOf(input int k);
    case (k)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic idleSweep();
    for (int k = 0; k < 3; k++) begin
      sValid[k] = 1'b0;
      sReady[k] = 1'b0;
      sData[k]  = '0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_     = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = 8'hFF;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    asserts++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid: got %0b want 0", outValid);
    end
    asserts++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %0b want 1", inReady);
    end
    asserts++;
    if (count !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_count: got %0d want 0", count);
    end
    asserts++;
    if (outData !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_out_data: got %h want 00", outData);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] pd [5];
    bit         pv [5];
    bit         eOv[5];
    logic [7:0] eOd[5];
    int         eCnt[5];
    int         peak;
    pd  = '{8'hAA, 8'h55, 8'h0F, 8'h00, 8'h00};
    pv  = '{1, 1, 1, 0, 0};
    eOv = '{0, 1, 1, 1, 0};
    eOd = '{8'h00, 8'hAA, 8'h55, 8'h0F, 8'h0F};
    eCnt = '{1, 2, 2, 1, 0};
    peak = 0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid  = pv[i];
      inData   = pd[i];
      outReady = 1'b1;
      #1;
      asserts++;
      if (inReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_in_ready[%0d]: got %0b want 1", i, inReady);
      end
      @(posedge clk);
      #1;
      asserts++;
      if (outValid !== eOv[i]) begin
        failures++;
        $display("[TB] FAIL stream_out_valid[%0d]: got %0b want %0b", i, outValid, eOv[i]);
      end
      if (eOv[i]) begin
        asserts++;
        if (outData !== eOd[i]) begin
          failures++;
          $display("[TB] FAIL stream_out_data[%0d]: got %h want %h", i, outData, eOd[i]);
        end
      end
      asserts++;
      if (int'(count) !== eCnt[i]) begin
        failures++;
        $display("[TB] FAIL stream_count[%0d]: got %0d want %0d", i, count, eCnt[i]);
      end
      if (int'(count) > peak) peak = int'(count);
    end
    asserts++;
    if (peak !== 2) begin
      failures++;
      $display("[TB] FAIL stream_peak_count: got %0d want 2", peak);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pd [3];
    bit         eIr[3];
    int         eCnt[3];
    logic [7:0] got[$];
    logic [7:0] want [3];
    pd   = '{8'hAA, 8'h55, 8'h33};
    eIr  = '{1, 1, 0};
    eCnt = '{1, 2, 2};
    want = '{8'hAA, 8'h55, 8'h33};
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inValid  = 1'b1;
      inData   = pd[i];
      outReady = 1'b0;
      #1;
      asserts++;
      if (inReady !== eIr[i]) begin
        failures++;
        $display("[TB] FAIL bp_in_ready[%0d]: got %0b want %0b", i, inReady, eIr[i]);
      end
      @(posedge clk);
      #1;
      asserts++;
      if (int'(count) !== eCnt[i]) begin
        failures++;
        $display("[TB] FAIL bp_count[%0d]: got %0d want %0d", i, count, eCnt[i]);
      end
    end
    asserts++;
    if (outData !== 8'hAA) begin
      failures++;
      $display("[TB] FAIL bp_head_data: got %h want aa", outData);
    end
    // Keep offering 33 for one cycle with the consumer ready, then drain.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid  = (i == 0);
      inData   = 8'h33;
      outReady = 1'b1;
      #1;
      if (outValid && outReady) got.push_back(outData);
      @(posedge clk);
    end
    #1;
    asserts++;
    if (got.size() !== 3) begin
      failures++;
      $display("[TB] FAIL bp_drain_len: got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      asserts++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("[TB] FAIL bp_drain_order[%0d]: got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    logic [7:0] want [6];
    want = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13};
    doReset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inValid  = 1'b1;
      inData   = 8'(i + 1);
      outReady = 1'b0;
      @(posedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid  = 1'b1;
      inData   = 8'h10 + 8'(i);
      outReady = 1'b1;
      #1;
      asserts++;
      if (inReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_in_ready[%0d]: got %0b want 1", i, inReady);
      end
      if (outValid) got.push_back(outData);
      @(posedge clk);
      #1;
      asserts++;
      if (count !== 2'd2) begin
        failures++;
        $display("[TB] FAIL b2b_count[%0d]: got %0d want 2", i, count);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      #1;
      if (outValid) got.push_back(outData);
      @(posedge clk);
    end
    asserts++;
    if (got.size() !== 6) begin
      failures++;
      $display("[TB] FAIL b2b_len: got %0d want 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      asserts++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("[TB] FAIL b2b_order[%0d]: got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        inValid  = 1'b1;
        inData   = 8'hA1 + 8'(i);
        outReady = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      flush    = 1'b1;
      rst_     = (pass == 1);
      inValid  = 1'b1;
      inData   = 8'hC3;
      outReady = 1'b1;
      #1;
      if (pass == 0) begin
        asserts++;
        if (inReady !== 1'b1) begin
          failures++;
          $display("[TB] FAIL flush_in_ready: got %0b want 1", inReady);
        end
      end
      @(posedge clk);
      #1;
      asserts++;
      if (count !== 2'd0) begin
        failures++;
        $display("[TB] FAIL flush_count[p%0d]: got %0d want 0", pass, count);
      end
      asserts++;
      if (outData !== 8'h00) begin
        failures++;
        $display("[TB] FAIL flush_out_data[p%0d]: got %h want 00", pass, outData);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        flush    = 1'b0;
        rst_     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        #1;
        asserts++;
        if (outValid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL flush_no_c3[p%0d,%0d]: out_valid %0b data %h want valid 0", pass, i, outValid, outData);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int stg [3];
    logic [31:0] msk [3];
    stg = '{1, 4, 16};
    msk = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0001};
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    idleSweep();
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        sValid[k] = (cyc < 660) && ($urandom_range(0, 9) < 6);
        sData[k]  = $urandom & msk[k];
        sReady[k] = (cyc >= 660) || ($urandom_range(0, 9) < 6);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        bit expIr;
        expIr = (qSize(k) < stg[k]) || sReady[k];
        asserts++;
        if (sIr[k] !== expIr) begin
          failures++;
          $display("[TB] FAIL sweep_in_ready[S%0d,c%0d]: got %0b want %0b", stg[k], cyc, sIr[k], expIr);
        end
        if (sOv[k] === 1'b1 && sReady[k]) begin
          asserts++;
          if (qSize(k) == 0) begin
            failures++;
            $display("[TB] FAIL sweep_phantom[S%0d,c%0d]: got data %h want nothing", stg[k], cyc, outOf(k));
          end else begin
            if (outOf(k) !== qFront(k)) begin
              failures++;
              $display("[TB] FAIL sweep_data[S%0d,c%0d]: got %h want %h", stg[k], cyc, outOf(k), qFront(k));
            end
            qPop(k);
          end
        end
        if (sValid[k] && expIr) qPush(k, sData[k]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        asserts++;
        if (cntOf(k) !== qSize(k)) begin
          failures++;
          $display("[TB] FAIL sweep_count[S%0d,c%0d]: got %0d want %0d", stg[k], cyc, cntOf(k), qSize(k));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (qSize(k) !== 0) begin
        failures++;
        $display("[TB] FAIL sweep_lost[S%0d]: got %0d undelivered want 0", stg[k], qSize(k));
      end
    end
    @(negedge clk);
    idleSweep();
  endtask

  initial begin
    rst_     = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
    idleSweep();
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
